// File: rtl/ik_swift_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ik_swift_ctrl_pkg
// Shared types and constants for the ik_swift solver controller:
//   - word_t    : one datapath word at the default solver width
//   - state_e   : sequencer states
//   - ADDR_*    : word addresses of the host register map
//   - CTRL_* / STATUS_* : bit positions inside CTRL and STATUS
// ---------------------------------------------------------------------------
package ik_swift_ctrl_pkg;

    localparam int WIDTH_DEF = 27;
    typedef logic [WIDTH_DEF-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        CAPTURE
    } state_e;

    // Register map (word addresses)
    localparam int ADDR_DH_BASE     = 0;   // 24 words, address = 4*j + p
    localparam int ADDR_TARGET_BASE = 24;  // 6 words
    localparam int ADDR_Z_BASE      = 30;  // 3 words
    localparam int ADDR_JTYPE       = 33;
    localparam int ADDR_CTRL        = 34;
    localparam int ADDR_STATUS      = 35;
    localparam int ADDR_IRQ_EN      = 36;
    localparam int ADDR_DELTA_BASE  = 40;  // 6 words, read only

    // CTRL bits
    localparam int CTRL_START      = 0;
    localparam int CTRL_CLEAR_DONE = 1;

    // STATUS bits
    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_DONE    = 1;
    localparam int STATUS_CNT_LSB = 8;

    // Solve-cycle counter; wide enough for the largest legal latency (255)
    localparam int CNT_W = 8;

endpackage

// File: rtl/ik_swift_ctrl_if.sv
// ---------------------------------------------------------------------------
// ik_swift_ctrl_if
// Host register bus carried into the controller.
//   chipselect : access qualifier
//   write/read : strobes, qualified by chipselect
//   address    : word address (ADDR_W)
//   writedata  : write data (DATA_W)
//   readdata   : registered read data (DATA_W), driven by the slave
// Modports: master (host side), slave (controller side).
// ---------------------------------------------------------------------------
interface ik_swift_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata
    );
endinterface

// File: rtl/ik_swift_ctrl_regs.sv
// ---------------------------------------------------------------------------
// ik_swift_ctrl_regs
// Register file of the controller: solver staging words, captured delta
// results, optional IRQ_EN, and the registered read multiplexer.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus             : host register bus (slave modport), drives readdata
//   busy            : solve in progress; staging writes are dropped
//   capture         : latch eng_delta into the result registers this cycle
//   done, cnt       : sequencer status fields shown in STATUS
//   eng_delta       : solver result input
//   z, joint_type, dh_param, target : staged solver inputs
//   irq_en          : IRQ_EN bit (only with IK_SWIFT_CTRL_IRQ_EN)
// ---------------------------------------------------------------------------
module ik_swift_ctrl_regs
    import ik_swift_ctrl_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    ik_swift_ctrl_if.slave               bus,
    input  logic                         busy,
    input  logic                         capture,
    input  logic                         done,
    input  logic [CNT_W-1:0]             cnt,
    input  logic [5:0][WIDTH-1:0]        eng_delta,
    output logic [2:0][WIDTH-1:0]        z,
    output logic [5:0]                   joint_type,
    output logic [5:0][3:0][WIDTH-1:0]   dh_param,
    output logic [5:0][WIDTH-1:0]        target
`ifdef IK_SWIFT_CTRL_IRQ_EN
    ,
    output logic                         irq_en
`endif
);

    logic [5:0][3:0][WIDTH-1:0] dh_q, dh_d;
    logic [5:0][WIDTH-1:0]      target_q, target_d;
    logic [2:0][WIDTH-1:0]      z_q, z_d;
    logic [5:0]                 jtype_q, jtype_d;
    logic [5:0][WIDTH-1:0]      delta_q, delta_d;
    logic [DATA_W-1:0]          readdata_q, readdata_d;
    logic [DATA_W-1:0]          rd_mux;
`ifdef IK_SWIFT_CTRL_IRQ_EN
    logic                       irq_en_q, irq_en_d;
`endif

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wr_word;
    logic             unused_wdata;

    assign wr_en   = bus.chipselect & bus.write;
    assign rd_en   = bus.chipselect & bus.read;
    assign wr_word = bus.writedata[WIDTH-1:0];
    // Upper write-data bits are architecturally ignored.
    assign unused_wdata = ^bus.writedata;

    // Next-state for every register. Staging is frozen while busy so the
    // solver sees stable inputs for the whole solve.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        dh_d       = dh_q;
        target_d   = target_q;
        z_d        = z_q;
        jtype_d    = jtype_q;
        delta_d    = delta_q;
        readdata_d = readdata_q;
`ifdef IK_SWIFT_CTRL_IRQ_EN
        irq_en_d   = irq_en_q;
        if (wr_en && bus.address == ADDR_W'(ADDR_IRQ_EN))
            irq_en_d = bus.writedata[0];
`endif
        if (wr_en && !busy) begin
            for (int j = 0; j < 6; j++)
                for (int p = 0; p < 4; p++)
                    if (bus.address == ADDR_W'(ADDR_DH_BASE + 4*j + p))
                        dh_d[j][p] = wr_word;
            for (int i = 0; i < 6; i++)
                if (bus.address == ADDR_W'(ADDR_TARGET_BASE + i))
                    target_d[i] = wr_word;
            for (int i = 0; i < 3; i++)
                if (bus.address == ADDR_W'(ADDR_Z_BASE + i))
                    z_d[i] = wr_word;
            if (bus.address == ADDR_W'(ADDR_JTYPE))
                jtype_d = bus.writedata[5:0];
        end
        if (capture)
            delta_d = eng_delta;
        // readdata holds between reads
        if (rd_en)
            readdata_d = rd_mux;
    end

    // Read multiplexer; 27-bit words are sign-extended to the bus width.
    always_comb begin
        rd_mux = '0;
        for (int j = 0; j < 6; j++)
            for (int p = 0; p < 4; p++)
                if (bus.address == ADDR_W'(ADDR_DH_BASE + 4*j + p))
                    rd_mux = DATA_W'($signed(dh_q[j][p]));
        for (int i = 0; i < 6; i++) begin
            if (bus.address == ADDR_W'(ADDR_TARGET_BASE + i))
                rd_mux = DATA_W'($signed(target_q[i]));
            if (bus.address == ADDR_W'(ADDR_DELTA_BASE + i))
                rd_mux = DATA_W'($signed(delta_q[i]));
        end
        for (int i = 0; i < 3; i++)
            if (bus.address == ADDR_W'(ADDR_Z_BASE + i))
                rd_mux = DATA_W'($signed(z_q[i]));
        if (bus.address == ADDR_W'(ADDR_JTYPE))
            rd_mux[5:0] = jtype_q;
        if (bus.address == ADDR_W'(ADDR_STATUS)) begin
            rd_mux[STATUS_BUSY]                = busy;
            rd_mux[STATUS_DONE]                = done;
            rd_mux[STATUS_CNT_LSB +: CNT_W]    = cnt;
        end
`ifdef IK_SWIFT_CTRL_IRQ_EN
        if (bus.address == ADDR_W'(ADDR_IRQ_EN))
            rd_mux[0] = irq_en_q;
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: the staging and delta arrays are reset because the solver
        // inputs and results must read back as zero after rst, not as
        // whatever the array held before.
        if (rst) begin
            dh_q       <= '0;
            target_q   <= '0;
            z_q        <= '0;
            jtype_q    <= '0;
            delta_q    <= '0;
            readdata_q <= '0;
`ifdef IK_SWIFT_CTRL_IRQ_EN
            irq_en_q   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its _d input.
            dh_q       <= dh_d;
            target_q   <= target_d;
            z_q        <= z_d;
            jtype_q    <= jtype_d;
            delta_q    <= delta_d;
            readdata_q <= readdata_d;
`ifdef IK_SWIFT_CTRL_IRQ_EN
            irq_en_q   <= irq_en_d;
`endif
        end
    end

    assign bus.readdata = readdata_q;
    assign dh_param     = dh_q;
    assign target       = target_q;
    assign z            = z_q;
    assign joint_type   = jtype_q;
`ifdef IK_SWIFT_CTRL_IRQ_EN
    assign irq_en       = irq_en_q;
`endif

endmodule

// File: rtl/ik_swift_ctrl.sv
// ---------------------------------------------------------------------------
// ik_swift_ctrl
// Bus-slave sequencer owning one ik_swift solver. The host stages the arm
// description, writes CTRL.start; the controller pulses eng_rst for one
// cycle, holds eng_en for LATENCY cycles, captures eng_delta and sets the
// sticky done flag.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   bus                 : host register bus (slave modport)
//   eng_rst, eng_en     : solver reset / enable
//   eng_z, eng_joint_type, eng_dh_param, eng_target : staged solver inputs
//   eng_delta           : solver result
//   irq                 : done & IRQ_EN, registered (only with the macro)
// Optional feature macro: IK_SWIFT_CTRL_IRQ_EN (adds irq and IRQ_EN reg 36).
// ---------------------------------------------------------------------------
module ik_swift_ctrl
    import ik_swift_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int LATENCY = 64,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    ik_swift_ctrl_if.slave               bus,
    output logic                         eng_rst,
    output logic                         eng_en,
    output logic [2:0][WIDTH-1:0]        eng_z,
    output logic [5:0]                   eng_joint_type,
    output logic [5:0][3:0][WIDTH-1:0]   eng_dh_param,
    output logic [5:0][WIDTH-1:0]        eng_target,
    input  logic [5:0][WIDTH-1:0]        eng_delta
`ifdef IK_SWIFT_CTRL_IRQ_EN
    ,
    output logic                         irq
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             en_q, en_d;
    logic             clr_q, clr_d;

    logic ctrl_wr;
    logic start_req;
    logic clear_req;
    logic busy;
`ifdef IK_SWIFT_CTRL_IRQ_EN
    logic irq_en;
    logic irq_q, irq_d;
`endif

    assign ctrl_wr   = bus.chipselect & bus.write & (bus.address == ADDR_W'(ADDR_CTRL));
    assign start_req = ctrl_wr & bus.writedata[CTRL_START];
    assign clear_req = ctrl_wr & bus.writedata[CTRL_CLEAR_DONE];
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(LATENCY - 1))
                    state_d = CAPTURE;
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // An accepted start wins over everything (start + clear_done still
        // starts). Completion wins over a clear_done in the capture cycle so
        // a finished solve is never lost.
        if (state_q == IDLE && start_req)
            done_d = 1'b0;
        else if (state_q == CAPTURE)
            done_d = 1'b1;
        else if (clear_req)
            done_d = 1'b0;

        // Outputs are registered and aligned with the state they belong to.
        en_d  = (state_d == RUN);
        clr_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
        end
    end

    // The solver is held in reset for every cycle rst is asserted, not only
    // from the edge after it, so a mid-solve rst stops the engine at once.
    assign eng_rst = rst | clr_q;
    assign eng_en  = en_q & ~rst;

`ifdef IK_SWIFT_CTRL_IRQ_EN
    assign irq_d = done_q & irq_en;

    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

    ik_swift_ctrl_regs #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regs (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .capture    (state_q == CAPTURE),
        .done       (done_q),
        .cnt        (cnt_q),
        .eng_delta  (eng_delta),
        .z          (eng_z),
        .joint_type (eng_joint_type),
        .dh_param   (eng_dh_param),
        .target     (eng_target)
`ifdef IK_SWIFT_CTRL_IRQ_EN
        ,
        .irq_en     (irq_en)
`endif
    );

endmodule

// File: tb/tb_ik_swift_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ik_swift_ctrl
// Self-checking bench for ik_swift_ctrl. A register-map reference model
// (arrays indexed by address) predicts every read; expected read data is
// queued when the read is issued and a monitor compares readdata the cycle
// after. Solve timing, engine strobes and staged outputs are checked inline.
// Optional feature macro: IK_SWIFT_CTRL_IRQ_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ik_swift_ctrl;
    import ik_swift_ctrl_pkg::*;

    localparam int WIDTH   = 27;
    localparam int LATENCY = 64;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ik_swift_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic                       eng_rst, eng_en;
    logic [2:0][WIDTH-1:0]      eng_z;
    logic [5:0]                 eng_joint_type;
    logic [5:0][3:0][WIDTH-1:0] eng_dh_param;
    logic [5:0][WIDTH-1:0]      eng_target;
    logic [5:0][WIDTH-1:0]      eng_delta;
`ifdef IK_SWIFT_CTRL_IRQ_EN
    logic                       irq;
`endif

    ik_swift_ctrl #(
        .WIDTH(WIDTH), .LATENCY(LATENCY), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .eng_rst        (eng_rst),
        .eng_en         (eng_en),
        .eng_z          (eng_z),
        .eng_joint_type (eng_joint_type),
        .eng_dh_param   (eng_dh_param),
        .eng_target     (eng_target),
        .eng_delta      (eng_delta)
`ifdef IK_SWIFT_CTRL_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    word_t      m_stage [33];   // addresses 0..32
    logic [5:0] m_jtype;
    word_t      m_delta [6];
    bit         m_done, m_busy, m_irq_en;

    function automatic logic [31:0] sext(input word_t w);
        return {{(32-WIDTH_DEF){w[WIDTH_DEF-1]}}, w};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 33; i++) m_stage[i] = '0;
        for (int i = 0; i < 6; i++)  m_delta[i] = '0;
        m_jtype = '0; m_done = 0; m_busy = 0; m_irq_en = 0;
    endtask

    // STATUS counter bits are only predicted where a read uses an exact mask.
    function automatic logic [31:0] model_read(input int a);
        if (a < 33)                return sext(m_stage[a]);
        if (a == ADDR_JTYPE)       return {26'b0, m_jtype};
        if (a == ADDR_STATUS)      return {30'b0, m_done, m_busy};
`ifdef IK_SWIFT_CTRL_IRQ_EN
        if (a == ADDR_IRQ_EN)      return {31'b0, m_irq_en};
`endif
        if (a >= 40 && a <= 45)    return sext(m_delta[a-40]);
        return '0;
    endfunction

    task automatic model_write(input int a, input logic [31:0] d);
        if (!m_busy) begin
            if (a < 33)               m_stage[a] = d[WIDTH_DEF-1:0];
            else if (a == ADDR_JTYPE) m_jtype = d[5:0];
        end
`ifdef IK_SWIFT_CTRL_IRQ_EN
        if (a == ADDR_IRQ_EN) m_irq_en = d[0];
`endif
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        int          addr;
    } exp_t;
    exp_t exp_q[$];

    bit rd_seen;
    always @(posedge clk) rd_seen <= !rst && bus.chipselect && bus.read;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rd_unexpected: got 0x%08h, expected no read data", bus.readdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("read[%0d]", e.addr), bus.readdata & e.mask, e.data & e.mask);
            end
        end
    end

    // ---------------- bus driver (called at a falling edge) ----------------
    task automatic cyc(input bit w, input bit r, input int a, input logic [31:0] d);
        bus.chipselect = w | r;
        bus.write      = w;
        bus.read       = r;
        bus.address    = ADDR_W'(a);
        bus.writedata  = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, '0);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cyc(1, 0, a, d);
        model_write(a, d);
    endtask

    task automatic rd_exp(input int a, input logic [31:0] exp, input logic [31:0] mask);
        exp_q.push_back('{data: exp, mask: mask, addr: a});
        cyc(0, 1, a, '0);
    endtask

    task automatic rd(input int a);
        rd_exp(a, model_read(a), (a == ADDR_STATUS) ? 32'h3 : 32'hFFFF_FFFF);
    endtask

    task automatic check_eng();
        for (int j = 0; j < 6; j++)
            for (int p = 0; p < 4; p++)
                check($sformatf("eng_dh_param[%0d][%0d]", j, p), 32'(eng_dh_param[j][p]), 32'(m_stage[4*j+p]));
        for (int i = 0; i < 6; i++)
            check($sformatf("eng_target[%0d]", i), 32'(eng_target[i]), 32'(m_stage[ADDR_TARGET_BASE+i]));
        for (int i = 0; i < 3; i++)
            check($sformatf("eng_z[%0d]", i), 32'(eng_z[i]), 32'(m_stage[ADDR_Z_BASE+i]));
        check("eng_joint_type", 32'(eng_joint_type), 32'(m_jtype));
    endtask

    // Full solve: start write, then one loop iteration per clock with the
    // timing probes placed relative to the start write.
    task automatic run_solve(input logic [31:0] ctrl_val, input bit disturb);
        int en_n  = 0;
        int clr_n = 0;
        wr(ADDR_CTRL, ctrl_val);
        m_busy = 1;
        m_done = 0;
        for (int c = 1; c <= LATENCY + 3; c++) begin
            en_n  += int'(eng_en);
            clr_n += int'(eng_rst);
`ifdef IK_SWIFT_CTRL_IRQ_EN
            if (c == LATENCY + 3) check("irq_before_done", 32'(irq), 32'h0);
`endif
            if (c == 1)                       rd_exp(ADDR_STATUS, 32'h1, 32'hFFFF_FFFF);
            else if (c == 3)                  rd_exp(ADDR_DELTA_BASE, sext(m_delta[0]), 32'hFFFF_FFFF);
            else if (disturb && c == 11)      wr(ADDR_CTRL, 32'h1);
            else if (disturb && c == 12)      wr(ADDR_TARGET_BASE, 32'h123);
            else if (c == LATENCY + 1)        rd_exp(ADDR_STATUS, ((LATENCY - 1) << 8) | 1, 32'hFFFF_FFFF);
            else if (c == LATENCY + 2)        rd_exp(ADDR_STATUS, 32'h1, 32'h3);
            else if (c == LATENCY + 3)        rd_exp(ADDR_STATUS, 32'h2, 32'h3);
            else                              cyc(0, 0, 0, '0);
        end
        m_busy = 0;
        m_done = 1;
        for (int i = 0; i < 6; i++) m_delta[i] = eng_delta[i];
        check("eng_en_cycles", 32'(en_n), 32'(LATENCY));
        check("eng_rst_cycles", 32'(clr_n), 32'h1);
        check("eng_en_after", 32'(eng_en), 32'h0);
`ifdef IK_SWIFT_CTRL_IRQ_EN
        check("irq_after_done", 32'(irq), 32'(m_irq_en));
`endif
    endtask

    task automatic random_traffic(input int n);
        for (int k = 0; k < n; k++) begin
            int a;
            do a = int'($urandom_range(0, 47)); while (a == ADDR_CTRL || a == ADDR_STATUS);
            if ($urandom_range(0, 2) != 0) wr(a, $urandom());
            else                           rd(a);
        end
    endtask

    task automatic new_delta();
        for (int i = 0; i < 6; i++) eng_delta[i] = WIDTH'($urandom());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.chipselect = 0; bus.write = 0; bus.read = 0;
        bus.address = '0; bus.writedata = '0;
        eng_delta = '0;
        model_reset();

        // Reset state
        rst = 1;
        repeat (3) @(negedge clk);
        check("eng_rst_in_reset", 32'(eng_rst), 32'h1);
        check("eng_en_in_reset", 32'(eng_en), 32'h0);
        check("readdata_in_reset", bus.readdata, 32'h0);
        check_eng();
`ifdef IK_SWIFT_CTRL_IRQ_EN
        check("irq_in_reset", 32'(irq), 32'h0);
`endif
        rst = 0;
        @(negedge clk);
        check("eng_rst_idle", 32'(eng_rst), 32'h0);

        for (int a = 0; a < 64; a++) rd_exp(a, 32'h0, 32'hFFFF_FFFF);

        // Sign extension boundary and staged output
        wr(11, 32'h07FF_FFFF);
        rd(11);
        check("dh[2][3]_direct", 32'(eng_dh_param[2][3]), 32'h07FF_FFFF);
        wr(ADDR_JTYPE, 32'hFFFF_FFC5);
        rd(ADDR_JTYPE);

        random_traffic(60);
        check_eng();

        // readdata holds between reads
        rd(ADDR_TARGET_BASE);
        idle(3);
        check("readdata_hold", bus.readdata, model_read(ADDR_TARGET_BASE));

`ifdef IK_SWIFT_CTRL_IRQ_EN
        wr(ADDR_IRQ_EN, 32'h1);
        rd(ADDR_IRQ_EN);
`endif

        // Solve 1: engine returns i + 5
        for (int i = 0; i < 6; i++) eng_delta[i] = WIDTH'(i + 5);
        run_solve(32'h1, 1'b0);
        for (int a = 40; a <= 45; a++) rd(a);
        rd(ADDR_STATUS);

        // clear_done
        wr(ADDR_CTRL, 32'h2);
        m_done = 0;
`ifdef IK_SWIFT_CTRL_IRQ_EN
        check("irq_hold_one_cycle", 32'(irq), 32'h1);
        idle(1);
        check("irq_cleared", 32'(irq), 32'h0);
`endif
        rd(ADDR_STATUS);

        // Solve 2: restart and staging write attempted mid-solve
        random_traffic(20);
        new_delta();
        run_solve(32'h1, 1'b1);
        rd(ADDR_TARGET_BASE);
        check_eng();

        // Solve 3: start together with clear_done while done is set
        new_delta();
        run_solve(32'h3, 1'b0);
        for (int a = 40; a <= 45; a++) rd(a);

        // rst in the middle of a solve
        random_traffic(10);
        new_delta();
        wr(ADDR_CTRL, 32'h1);
        m_busy = 1;
        idle(20);
        rst = 1;
        @(negedge clk);
        check("mid_rst_eng_en", 32'(eng_en), 32'h0);
        check("mid_rst_eng_rst", 32'(eng_rst), 32'h1);
        check("mid_rst_readdata", bus.readdata, 32'h0);
        rst = 0;
        model_reset();
        exp_q.delete();
        @(negedge clk);
        check("post_rst_eng_rst", 32'(eng_rst), 32'h0);
        check("post_rst_eng_en", 32'(eng_en), 32'h0);
        check_eng();
        rd_exp(ADDR_STATUS, 32'h0, 32'hFFFF_FFFF);
        rd(ADDR_TARGET_BASE);
        rd(ADDR_DELTA_BASE);
`ifdef IK_SWIFT_CTRL_IRQ_EN
        rd(ADDR_IRQ_EN);
`endif

        // Fresh solve after reset
        random_traffic(10);
        new_delta();
        run_solve(32'h1, 1'b0);
        for (int a = 40; a <= 45; a++) rd(a);

        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
